// File: rtl/srl_delay_ctrl.sv
// Variable-length shift-register delay line with valid/ready handshake.
// Data stages are never reset so they can map to SRL primitives; fill/length counters carry state.
module srl_delay_ctrl #(
  parameter int width    = 1,
  parameter int depth    = 130,
  parameter int init_len = 4
) (
  input  logic             clk,
  input  logic             r,
  input  logic [width-1:0] i,
  input  logic             i_valid,
  output logic             i_ready,
  output logic [width-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  input  logic [31:0]      l_req,
  input  logic             l_load,
  input  logic             flush,
  output logic [31:0]      l_cur,
  output logic [31:0]      fill,
  output logic [1:0]       st
);

  localparam int AW = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [31:0] DEPTH = 32'(depth);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [width-1:0] sr [depth];
  logic             shift;
  logic [31:0]      fill_n, l_n, l_clamp;
  logic [AW-1:0]    tap;

  assign q_valid = (fill >= l_cur);
  assign i_ready = !r && !flush && (!q_valid || q_ready);
  assign shift   = i_valid && i_ready;
  // l_cur is held in 1..depth, so the tap index never goes out of range
  assign tap     = AW'(l_cur - 32'd1);
  assign q       = sr[tap];
  assign st      = state;

  // No reset on the data stages; only the shift enable gates them.
  always_ff @(posedge clk) begin
    if (shift) begin
      sr[0] <= i;
      for (int k = 1; k < depth; k++) sr[k] <= sr[k-1];
    end
  end

  always_comb begin
    l_clamp = l_req;
    if (l_req == 32'd0)   l_clamp = 32'd1;
    else if (l_req > DEPTH) l_clamp = DEPTH;

    fill_n = fill;
    if (flush)                        fill_n = 32'd0;
    else if (shift && fill != DEPTH)  fill_n = fill + 32'd1;

    l_n = l_load ? l_clamp : l_cur;

    // State tracks the post-edge fill against the post-edge length
    state_n = RUN;
    if (fill_n == 32'd0)   state_n = EMPTY;
    else if (fill_n < l_n) state_n = FILL;
  end

  always_ff @(posedge clk) begin
    if (r) begin
      state <= EMPTY;
      fill  <= 32'd0;
      l_cur <= 32'(init_len);
    end else begin
      state <= state_n;
      fill  <= fill_n;
      l_cur <= l_n;
    end
  end

endmodule

// File: tb/tb_srl_delay_ctrl.sv
// Directed vector bench for srl_delay_ctrl: table of per-cycle stimulus with expected
// post-edge state, plus a looped saturation sequence at full depth.
module tb_srl_delay_ctrl;

  localparam int W = 8;
  localparam int D = 130;

  logic          clk = 1'b0;
  logic          r = 1'b1;
  logic [W-1:0]  i = '0;
  logic          i_valid = 1'b0;
  logic          i_ready;
  logic [W-1:0]  q;
  logic          q_valid;
  logic          q_ready = 1'b1;
  logic [31:0]   l_req = '0;
  logic          l_load = 1'b0;
  logic          flush = 1'b0;
  logic [31:0]   l_cur;
  logic [31:0]   fill;
  logic [1:0]    st;

  int nchk = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  srl_delay_ctrl #(.width(W), .depth(D), .init_len(4)) dut (
    .clk(clk), .r(r), .i(i), .i_valid(i_valid), .i_ready(i_ready),
    .q(q), .q_valid(q_valid), .q_ready(q_ready),
    .l_req(l_req), .l_load(l_load), .flush(flush),
    .l_cur(l_cur), .fill(fill), .st(st)
  );

  typedef struct {
    logic        r, iv;
    logic [W-1:0] d;
    logic        qr, ld;
    logic [31:0] lr;
    logic        fl;
    logic        ir;    // expected i_ready before the edge
    logic        qv;    // expected after the edge
    logic [W-1:0] q;
    logic [31:0] fill, l;
    logic [1:0]  st;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic r_, iv_, input int d_, input logic qr_, ld_,
                              input int lr_, input logic fl_, ir_, qv_,
                              input int q_, f_, l_, st_);
    vec_t v;
    v.r = r_; v.iv = iv_; v.d = W'(d_); v.qr = qr_; v.ld = ld_; v.lr = 32'(lr_); v.fl = fl_;
    v.ir = ir_; v.qv = qv_; v.q = W'(q_); v.fill = 32'(f_); v.l = 32'(l_); v.st = 2'(st_);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    r = v.r; i_valid = v.iv; i = v.d; q_ready = v.qr;
    l_load = v.ld; l_req = v.lr; flush = v.fl;
    #1 chk($sformatf("v%0d i_ready", idx), 32'(i_ready), 32'(v.ir));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d fill", idx), fill, v.fill);
    chk($sformatf("v%0d l_cur", idx), l_cur, v.l);
    chk($sformatf("v%0d st", idx), 32'(st), 32'(v.st));
    chk($sformatf("v%0d q_valid", idx), 32'(q_valid), 32'(v.qv));
    if (v.qv) chk($sformatf("v%0d q", idx), 32'(q), 32'(v.q));
  endtask

  initial begin
    // reset, then fill at l=4
    vq.push_back(mk(1,1,0,1,0,0,0, 0,0,0,0,4,0));
    vq.push_back(mk(0,1,1,1,0,0,0, 1,0,0,1,4,1));
    vq.push_back(mk(0,1,2,1,0,0,0, 1,0,0,2,4,1));
    vq.push_back(mk(0,1,3,1,0,0,0, 1,0,0,3,4,1));
    vq.push_back(mk(0,1,4,1,0,0,0, 1,1,1,4,4,2));
    vq.push_back(mk(0,1,5,1,0,0,0, 1,1,2,5,4,2));
    vq.push_back(mk(0,1,6,1,0,0,0, 1,1,3,6,4,2));
    vq.push_back(mk(0,1,7,1,0,0,0, 1,1,4,7,4,2));
    vq.push_back(mk(0,1,8,1,0,0,0, 1,1,5,8,4,2));
    // backpressure: q holds 5
    for (int k = 0; k < 3; k++) vq.push_back(mk(0,1,9,0,0,0,0, 0,1,5,8,4,2));
    vq.push_back(mk(0,1,9,1,0,0,0, 1,1,6,9,4,2));
    // flush, refill to exactly 4, then lengthen to 6
    vq.push_back(mk(0,0,0,1,0,0,1, 0,0,0,0,4,0));
    vq.push_back(mk(0,1,10,1,0,0,0, 1,0,0,1,4,1));
    vq.push_back(mk(0,1,11,1,0,0,0, 1,0,0,2,4,1));
    vq.push_back(mk(0,1,12,1,0,0,0, 1,0,0,3,4,1));
    vq.push_back(mk(0,1,13,1,0,0,0, 1,1,10,4,4,2));
    vq.push_back(mk(0,0,0,1,1,6,0, 1,0,0,4,6,1));
    vq.push_back(mk(0,1,14,1,0,0,0, 1,0,0,5,6,1));
    vq.push_back(mk(0,1,15,1,0,0,0, 1,1,10,6,6,2));
    vq.push_back(mk(0,1,16,1,0,0,0, 1,1,11,7,6,2));
    vq.push_back(mk(0,1,17,1,0,0,0, 1,1,12,8,6,2));
    vq.push_back(mk(0,1,18,1,0,0,0, 1,1,13,9,6,2));
    vq.push_back(mk(0,1,19,1,0,0,0, 1,1,14,10,6,2));
    vq.push_back(mk(0,1,20,1,0,0,0, 1,1,15,11,6,2));
    // shorten to 3, clamp low and high
    vq.push_back(mk(0,0,0,1,1,3,0, 1,1,18,11,3,2));
    vq.push_back(mk(0,0,0,1,1,0,0, 1,1,20,11,1,2));
    vq.push_back(mk(0,0,0,1,1,200,0, 1,0,0,11,130,1));
    // flush + load together, then 2 shifts to RUN
    vq.push_back(mk(0,1,21,1,1,2,1, 0,0,0,0,2,0));
    vq.push_back(mk(0,1,22,1,0,0,0, 1,0,0,1,2,1));
    vq.push_back(mk(0,1,23,1,0,0,0, 1,1,22,2,2,2));
    vq.push_back(mk(0,1,24,1,0,0,0, 1,1,23,3,2,2));
    // reset mid-RUN with i_valid high, refill
    vq.push_back(mk(1,1,25,1,0,0,0, 0,0,0,0,4,0));
    vq.push_back(mk(0,1,26,1,0,0,0, 1,0,0,1,4,1));
    vq.push_back(mk(0,1,27,1,0,0,0, 1,0,0,2,4,1));
    vq.push_back(mk(0,1,28,1,0,0,0, 1,0,0,3,4,1));
    vq.push_back(mk(0,1,29,1,0,0,0, 1,1,26,4,4,2));
    vq.push_back(mk(0,1,30,1,0,0,0, 1,1,27,5,4,2));
    // l=1: EMPTY straight to RUN; shift and load in the same cycle
    vq.push_back(mk(0,0,0,1,1,1,1, 0,0,0,0,1,0));
    vq.push_back(mk(0,1,31,1,0,0,0, 1,1,31,1,1,2));
    vq.push_back(mk(0,1,32,1,1,2,0, 1,1,31,2,2,2));

    foreach (vq[n]) apply(vq[n], n);

    // full-depth saturation: fill stops at depth, tap reads the oldest word
    apply(mk(0,0,0,1,1,D,1, 0,0,0,0,D,0), 1000);
    for (int k = 1; k <= D + 1; k++)
      apply(mk(0,1,k,1,0,0,0, 1, (k >= D), k - D + 1, (k < D) ? k : D, D, (k < D) ? 1 : 2),
            1000 + k);

    // backpressure at saturation keeps fill and q
    apply(mk(0,1,200,0,0,0,0, 0,1,2,D,D,2), 2000);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
